// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for param_seq_alu:
//   - op-code localparams, encoded {ainv, binv, sel[1:0]}, plus MUL
//   - FSM state enum for the sequencing top level
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : alu_pkg

// File: rtl/param_seq_alu_if.sv
// ---------------------------------------------------------------------------
// param_seq_alu_if
// Valid/ready operand port and valid/ready result port of param_seq_alu.
//   master : the producer/consumer around the ALU (drives operands, out_ready)
//   slave  : the ALU itself (drives in_ready, result and flags)
// ---------------------------------------------------------------------------
interface param_seq_alu_if #(
   parameter int WIDTH = 32
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             illegal;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, carry, overflow, illegal
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, carry, overflow, illegal
   );

endinterface : param_seq_alu_if

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational single-cycle ALU slice.
// Ports:
//   a_i, b_i     : WIDTH-bit operands
//   op_i         : 4-bit op code
//   result_o     : operation result (0 for MUL and unassigned codes)
//   carry_o      : carry out of bit WIDTH-1 for ADD/SUB/SLT, else 0
//   overflow_o   : signed overflow for ADD/SUB/SLT, else 0
//   illegal_o    : op code is unassigned
// MUL is a legal code here but is computed by the sequencer in the top level.
// ---------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o,
   output logic             overflow_o,
   output logic             illegal_o
);

   logic [WIDTH:0] add_s;
   logic [WIDTH:0] sub_s;
   logic           add_ovf_s;
   logic           sub_ovf_s;
   logic           slt_s;

   assign add_s = {1'b0, a_i} + {1'b0, b_i};
   assign sub_s = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

   // Overflow: operands of equal sign (after B inversion) give a result of other sign.
   assign add_ovf_s = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_s[WIDTH-1] != a_i[WIDTH-1]);
   assign sub_ovf_s = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_s[WIDTH-1] != a_i[WIDTH-1]);

   // True signed less-than: sign of A-B corrected by its overflow.
   assign slt_s = sub_s[WIDTH-1] ^ sub_ovf_s;

   // Result and flag selection per op code.
   always_comb begin
      result_o   = {WIDTH{1'b0}};
      carry_o    = 1'b0;
      overflow_o = 1'b0;
      illegal_o  = 1'b0;
      case (op_i)
         OP_AND: result_o = a_i & b_i;
         OP_OR:  result_o = a_i | b_i;
         OP_NOR: result_o = ~a_i & ~b_i;
         OP_ADD: begin
            result_o   = add_s[WIDTH-1:0];
            carry_o    = add_s[WIDTH];
            overflow_o = add_ovf_s;
         end
         OP_SUB: begin
            result_o   = sub_s[WIDTH-1:0];
            carry_o    = sub_s[WIDTH];
            overflow_o = sub_ovf_s;
         end
         OP_SLT: begin
            result_o   = {{(WIDTH-1){1'b0}}, slt_s};
            carry_o    = sub_s[WIDTH];
            overflow_o = sub_ovf_s;
         end
         OP_MUL: begin
            result_o = {WIDTH{1'b0}};
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule : alu_core

// File: rtl/param_seq_alu.sv
// ---------------------------------------------------------------------------
// param_seq_alu
// Handshaked, registered ALU with a multi-cycle unsigned shift-add multiply.
// Ports:
//   clk     : single clock, all state on the rising edge
//   reset   : synchronous, active-high reset
//   alu_bus : slave side of param_seq_alu_if
//             in_valid/in_ready/a/b/op        operand port
//             out_valid/out_ready             result port handshake
//             result/zero/carry/overflow/illegal  registered result and flags
// Single-cycle ops register their result on the accepting edge; MUL runs
// WIDTH iterations, the last of which registers the product.
// ---------------------------------------------------------------------------
module param_seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   param_seq_alu_if.slave         alu_bus
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 carry_q, carry_d;
   logic                 overflow_q, overflow_d;
   logic                 illegal_q, illegal_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 in_ready_s;
   logic                 out_valid_s;
   logic                 accept_s;
   logic                 is_mul_s;
   logic                 mul_last_s;
   logic [WIDTH:0]       partial_s;
   logic [2*WIDTH-1:0]   acc_step_s;

   logic [WIDTH-1:0]     core_result_s;
   logic                 core_carry_s;
   logic                 core_overflow_s;
   logic                 core_illegal_s;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a_i        (alu_bus.a),
      .b_i        (alu_bus.b),
      .op_i       (alu_bus.op),
      .result_o   (core_result_s),
      .carry_o    (core_carry_s),
      .overflow_o (core_overflow_s),
      .illegal_o  (core_illegal_s)
   );

   assign accept_s = alu_bus.in_valid & in_ready_s;
   assign is_mul_s = (alu_bus.op == OP_MUL);

   // The multiplier lives in the low half of the accumulator: its bit 0 picks
   // the add, and each shift pulls one product bit in from the top.
   assign partial_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign acc_step_s = {partial_s, acc_q[WIDTH-1:1]};
   assign mul_last_s = (cnt_q == CNT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = is_mul_s ? ST_MUL : ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (mul_last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_DONE: begin
            if (accept_s) begin
               state_d = is_mul_s ? ST_MUL : ST_DONE;
            end else if (alu_bus.out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state; in_ready is held low during reset.
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_s = ~reset;
         end
         ST_MUL: begin
            in_ready_s = 1'b0;
         end
         ST_DONE: begin
            in_ready_s  = alu_bus.out_ready & ~reset;
            out_valid_s = 1'b1;
         end
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // Datapath next-state: operand capture, multiply iteration, result/flags.
   always_comb begin
      result_d   = result_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      illegal_d  = illegal_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
               if (is_mul_s) begin
                  mcand_d = alu_bus.a;
                  acc_d   = {{WIDTH{1'b0}}, alu_bus.b};
                  cnt_d   = {CNT_W{1'b0}};
               end else begin
                  result_d   = core_result_s;
                  zero_d     = (core_result_s == {WIDTH{1'b0}});
                  carry_d    = core_carry_s;
                  overflow_d = core_overflow_s;
                  illegal_d  = core_illegal_s;
               end
            end else begin
               result_d = result_q;
            end
         end
         ST_MUL: begin
            acc_d = acc_step_s;
            cnt_d = cnt_q + CNT_ONE;
            if (mul_last_s) begin
               result_d   = acc_step_s[WIDTH-1:0];
               zero_d     = (acc_step_s[WIDTH-1:0] == {WIDTH{1'b0}});
               carry_d    = |acc_step_s[2*WIDTH-1:WIDTH];
               overflow_d = 1'b0;
               illegal_d  = 1'b0;
            end else begin
               result_d = result_q;
            end
         end
         default: begin
            result_d = result_q;
         end
      endcase
   end

   // Datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_q   <= {WIDTH{1'b0}};
         zero_q     <= 1'b1;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         illegal_q  <= 1'b0;
         mcand_q    <= {WIDTH{1'b0}};
         acc_q      <= {(2*WIDTH){1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
      end else begin
         result_q   <= result_d;
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         illegal_q  <= illegal_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
      end
   end

   assign alu_bus.in_ready  = in_ready_s;
   assign alu_bus.out_valid = out_valid_s;
   assign alu_bus.result    = result_q;
   assign alu_bus.zero      = zero_q;
   assign alu_bus.carry     = carry_q;
   assign alu_bus.overflow  = overflow_q;
   assign alu_bus.illegal   = illegal_q;

endmodule : param_seq_alu

// File: tb/tb_param_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_param_seq_alu
// Directed bench for param_seq_alu at WIDTH=32 and WIDTH=8. A vector table
// covers each op with hand-computed results, flags and latency; hand-written
// sequences cover reset, backpressure and reset during a multiply.
// ---------------------------------------------------------------------------
module tb_param_seq_alu;
   import alu_pkg::*;

   logic clk;
   logic reset;

   int checks;
   int errors;

   param_seq_alu_if #(.WIDTH(32)) if32 ();
   param_seq_alu_if #(.WIDTH(8))  if8  ();

   param_seq_alu #(.WIDTH(32)) dut32 (
      .clk     (clk),
      .reset   (reset),
      .alu_bus (if32)
   );

   param_seq_alu #(.WIDTH(8)) dut8 (
      .clk     (clk),
      .reset   (reset),
      .alu_bus (if8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          w8;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        z;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic sel_ov(input bit w8);
      return w8 ? if8.out_valid : if32.out_valid;
   endfunction

   // Apply one vector with out_ready high and compare everything it produces.
   task automatic run_vec(input vec_t v);
      int k;
      logic [31:0] r;
      logic c, ov, z, il, rdy;
      if (v.w8) begin
         if8.a = v.a[7:0]; if8.b = v.b[7:0]; if8.op = v.op; if8.in_valid = 1'b1;
         #1 rdy = if8.in_ready;
      end else begin
         if32.a = v.a; if32.b = v.b; if32.op = v.op; if32.in_valid = 1'b1;
         #1 rdy = if32.in_ready;
      end
      chk({v.name, " in_ready"}, 64'(rdy), 64'd1);
      @(posedge clk); #1;
      if32.in_valid = 1'b0;
      if8.in_valid  = 1'b0;
      k = 0;
      while (!sel_ov(v.w8) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk({v.name, " latency"}, 64'(k + 1), 64'(v.lat));
      if (v.w8) begin
         r = {24'd0, if8.result}; c = if8.carry; ov = if8.overflow; z = if8.zero; il = if8.illegal;
      end else begin
         r = if32.result; c = if32.carry; ov = if32.overflow; z = if32.zero; il = if32.illegal;
      end
      chk({v.name, " result"},   64'(r),  64'(v.res));
      chk({v.name, " carry"},    64'(c),  64'(v.c));
      chk({v.name, " overflow"}, 64'(ov), 64'(v.v));
      chk({v.name, " zero"},     64'(z),  64'(v.z));
      chk({v.name, " illegal"},  64'(il), 64'(v.ill));
      @(posedge clk); #1;
   endtask

   function automatic vec_t mk(input string n, input bit w8, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                               input logic c, input logic v, input logic z, input logic ill,
                               input int lat);
      vec_t t;
      t.name = n; t.w8 = w8; t.op = op; t.a = a; t.b = b; t.res = res;
      t.c = c; t.v = v; t.z = z; t.ill = ill; t.lat = lat;
      return t;
   endfunction

   initial begin
      int hits;
      checks = 0;
      errors = 0;

      //                 name       w8    op            a             b             result        c     v     z     ill   lat
      vecs.push_back(mk("add_ovf",  1'b0, OP_ADD,       32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk("sub_eq",   1'b0, OP_SUB,       32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1));
      vecs.push_back(mk("slt_neg",  1'b0, OP_SLT,       32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk("slt_pos",  1'b0, OP_SLT,       32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1));
      vecs.push_back(mk("slt_3_5",  1'b0, OP_SLT,       32'h00000003, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("and",      1'b0, OP_AND,       32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("or",       1'b0, OP_OR,        32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("nor",      1'b0, OP_NOR,       32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1));
      vecs.push_back(mk("add_wrap", 1'b0, OP_ADD,       32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1));
      vecs.push_back(mk("sub_brw",  1'b0, OP_SUB,       32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("illegal",  1'b0, 4'b0101,      32'h00001234, 32'h00005678, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1));
      vecs.push_back(mk("mul_ffff", 1'b0, OP_MUL,       32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 33));
      vecs.push_back(mk("mul_hi",   1'b0, OP_MUL,       32'h80000000, 32'h00000002, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 33));
      vecs.push_back(mk("mul_7x6",  1'b0, OP_MUL,       32'h00000007, 32'h00000006, 32'h0000002A, 1'b0, 1'b0, 1'b0, 1'b0, 33));
      vecs.push_back(mk("mul_max",  1'b0, OP_MUL,       32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 33));
      vecs.push_back(mk("w8_add",   1'b1, OP_ADD,       32'h00000080, 32'h00000080, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1));
      vecs.push_back(mk("w8_mul",   1'b1, OP_MUL,       32'h0000000F, 32'h00000011, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0, 9));
      vecs.push_back(mk("w8_mulc",  1'b1, OP_MUL,       32'h00000010, 32'h00000010, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 9));

      if32.in_valid = 1'b0; if32.a = 32'd0; if32.b = 32'd0; if32.op = 4'd0; if32.out_ready = 1'b1;
      if8.in_valid  = 1'b0; if8.a  = 8'd0;  if8.b  = 8'd0;  if8.op  = 4'd0; if8.out_ready  = 1'b1;

      // Reset state.
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst out_valid", 64'(if32.out_valid), 64'd0);
      chk("rst result",    64'(if32.result),    64'd0);
      chk("rst zero",      64'(if32.zero),      64'd1);
      chk("rst carry",     64'(if32.carry),     64'd0);
      chk("rst overflow",  64'(if32.overflow),  64'd0);
      chk("rst illegal",   64'(if32.illegal),   64'd0);
      chk("rst in_ready",  64'(if32.in_ready),  64'd0);
      reset = 1'b0;
      #1;
      chk("post-rst in_ready", 64'(if32.in_ready), 64'd1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure: AND result held while a queued ADD waits.
      if32.out_ready = 1'b0;
      if32.a = 32'hFFFF0000; if32.b = 32'h0F0F0F0F; if32.op = OP_AND; if32.in_valid = 1'b1;
      @(posedge clk); #1;
      if32.a = 32'h00000001; if32.b = 32'h00000002; if32.op = OP_ADD;
      for (int i = 0; i < 5; i++) begin
         chk("bp in_ready",  64'(if32.in_ready),  64'd0);
         chk("bp out_valid", 64'(if32.out_valid), 64'd1);
         chk("bp result",    64'(if32.result),    64'h0F0F0000);
         if32.a = 32'(i + 100);
         @(posedge clk); #1;
      end
      if32.a = 32'h00000001;
      if32.out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 64'(if32.in_ready), 64'd1);
      @(posedge clk); #1;
      if32.in_valid = 1'b0;
      chk("bp next out_valid", 64'(if32.out_valid), 64'd1);
      chk("bp next result",    64'(if32.result),    64'd3);
      @(posedge clk); #1;
      chk("bp drained", 64'(if32.out_valid), 64'd0);

      // Reset at cycle 10 of a multiply.
      if32.a = 32'h00000003; if32.b = 32'h00000005; if32.op = OP_MUL; if32.in_valid = 1'b1;
      @(posedge clk); #1;
      if32.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("mulrst in_ready", 64'(if32.in_ready), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mulrst out_valid", 64'(if32.out_valid), 64'd0);
      chk("mulrst result",    64'(if32.result),    64'd0);
      chk("mulrst zero",      64'(if32.zero),      64'd1);
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         if (if32.out_valid) hits++;
         @(posedge clk); #1;
      end
      chk("mulrst no stale result", 64'(hits), 64'd0);
      run_vec(mk("add_after", 1'b0, OP_ADD, 32'h00000002, 32'h00000003, 32'h00000005,
                 1'b0, 1'b0, 1'b0, 1'b0, 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_param_seq_alu
